// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
//   Y86-64 execute stage. Selects the ALU operands from the E pipeline
//   register, computes the ALU result and its flags, and keeps the
//   condition-code register. It evaluates the branch/cmov condition on the
//   current flags and loads the M pipeline register on every rising edge.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   E_*                E pipeline register outputs (stat, icode, ifun,
//                      valC, valA, valB, dstE, dstM)
//   m_exc, W_exc       a later stage holds an exception; blocks cc update
//   M_bubble           load a nop bubble into M on this edge
//   e_valE/e_dstE/e_Cnd  unregistered results for forwarding and hazards
//   cc                 condition-code register {ZF,SF,OF}
//   M_*                M pipeline register outputs
// ---------------------------------------------------------------------------
module execute_stage #(
  parameter int         DATA_W = 64,
  parameter logic [3:0] RNONE  = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        E_stat,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        E_ifun,
  input  logic [DATA_W-1:0] E_valC,
  input  logic [DATA_W-1:0] E_valA,
  input  logic [DATA_W-1:0] E_valB,
  input  logic [3:0]        E_dstE,
  input  logic [3:0]        E_dstM,
  input  logic              m_exc,
  input  logic              W_exc,
  input  logic              M_bubble,
  output logic [DATA_W-1:0] e_valE,
  output logic [3:0]        e_dstE,
  output logic              e_Cnd,
  output logic [2:0]        cc,
  output logic [3:0]        M_stat,
  output logic [3:0]        M_icode,
  output logic              M_Cnd,
  output logic [DATA_W-1:0] M_valE,
  output logic [DATA_W-1:0] M_valA,
  output logic [3:0]        M_dstE,
  output logic [3:0]        M_dstM
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] STAT_AOK = 4'h1;
  localparam logic [2:0] CC_RESET = 3'b100;

  localparam logic [DATA_W-1:0] PLUS8  = DATA_W'(8);
  localparam logic [DATA_W-1:0] MINUS8 = ~DATA_W'(7);   // two's complement -8

  typedef struct packed {
    logic [3:0]        stat;
    logic [3:0]        icode;
    logic              cnd;
    logic [DATA_W-1:0] val_e;
    logic [DATA_W-1:0] val_a;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
  } m_reg_t;

  logic [DATA_W-1:0] alu_a, alu_b, alu_res;
  logic              alu_of;
  logic              set_cc;
  logic [2:0]        new_flags;
  logic [2:0]        cc_d, cc_q;
  m_reg_t            m_d, m_q, m_bubble_val;

  // Operand selection.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned, which would infer a latch.
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (E_icode)
      I_RRMOVQ, I_OPQ:             alu_a = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
      I_CALL, I_PUSHQ:             alu_a = MINUS8;
      I_RET, I_POPQ:               alu_a = PLUS8;
      default:                     alu_a = '0;
    endcase
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = E_valB;
      default:                                                   alu_b = '0;
    endcase
  end

  // ALU. Only OPq decodes ifun; everything else is an address/move add.
  always_comb begin
    alu_res = alu_b + alu_a;
    alu_of  = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) &&
              (alu_res[DATA_W-1] != alu_a[DATA_W-1]);
    if (E_icode == I_OPQ) begin
      case (E_ifun)
        4'd0: ;  // add, already computed above
        4'd1: begin
          alu_res = alu_b - alu_a;
          alu_of  = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) &&
                    (alu_res[DATA_W-1] != alu_b[DATA_W-1]);
        end
        4'd2: begin
          alu_res = alu_b & alu_a;
          alu_of  = 1'b0;
        end
        4'd3: begin
          alu_res = alu_b ^ alu_a;
          alu_of  = 1'b0;
        end
        default: begin
          alu_res = '0;
          alu_of  = 1'b0;
        end
      endcase
    end
  end

  assign new_flags = {alu_res == '0, alu_res[DATA_W-1], alu_of};
  assign set_cc    = (E_icode == I_OPQ) & ~m_exc & ~W_exc & ~rst;
  assign cc_d      = set_cc ? new_flags : cc_q;

  // Condition uses the flags already in cc, not the ones being produced now.
  always_comb begin
    logic zf, sf, of;
    {zf, sf, of} = cc_q;
    case (E_ifun)
      4'd0:    e_Cnd = 1'b1;
      4'd1:    e_Cnd = (sf ^ of) | zf;
      4'd2:    e_Cnd = sf ^ of;
      4'd3:    e_Cnd = zf;
      4'd4:    e_Cnd = ~zf;
      4'd5:    e_Cnd = ~(sf ^ of);
      4'd6:    e_Cnd = ~(sf ^ of) & ~zf;
      default: e_Cnd = 1'b0;
    endcase
  end

  // A cmov whose condition fails writes nowhere.
  assign e_dstE = ((E_icode == I_RRMOVQ) && !e_Cnd) ? RNONE : E_dstE;
  assign e_valE = alu_res;

  assign m_bubble_val = '{stat: STAT_AOK, icode: I_NOP, cnd: 1'b0,
                          val_e: '0, val_a: '0, dst_e: RNONE, dst_m: RNONE};

  always_comb begin
    m_d = '{stat: E_stat, icode: E_icode, cnd: e_Cnd, val_e: e_valE,
            val_a: E_valA, dst_e: e_dstE, dst_m: E_dstM};
    if (M_bubble) m_d = m_bubble_val;
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_q <= CC_RESET;
      m_q  <= m_bubble_val;
    end else begin
      cc_q <= cc_d;
      m_q  <= m_d;
    end
  end

  assign cc      = cc_q;
  assign M_stat  = m_q.stat;
  assign M_icode = m_q.icode;
  assign M_Cnd   = m_q.cnd;
  assign M_valE  = m_q.val_e;
  assign M_valA  = m_q.val_a;
  assign M_dstE  = m_q.dst_e;
  assign M_dstM  = m_q.dst_m;

  // I_HALT is named for readability of the icode map; it takes the defaults.
  logic unused_halt;
  assign unused_halt = (I_HALT == 4'h0);

endmodule

// File: tb/tb_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_stage
//   Directed vectors with hand-computed results. The driver checks the
//   combinational e_* outputs and queues the expected M register and cc
//   contents; a monitor pops one entry after every rising edge and compares.
// ---------------------------------------------------------------------------
module tb_execute_stage;

  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        E_stat, E_icode, E_ifun, E_dstE, E_dstM;
  logic [DATA_W-1:0] E_valC, E_valA, E_valB;
  logic              m_exc, W_exc, M_bubble;
  logic [DATA_W-1:0] e_valE, M_valE, M_valA;
  logic [3:0]        e_dstE, M_stat, M_icode, M_dstE, M_dstM;
  logic              e_Cnd, M_Cnd;
  logic [2:0]        cc;

  execute_stage #(.DATA_W(DATA_W), .RNONE(4'hF)) dut (
    .clk(clk), .rst(rst),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_exc(m_exc), .W_exc(W_exc), .M_bubble(M_bubble),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd), .cc(cc),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]        stat, icode;
    logic              cnd;
    logic [DATA_W-1:0] val_e, val_a;
    logic [3:0]        dst_e, dst_m;
    logic [2:0]        cc;
    int                id;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one E-register vector, check e_* now, queue expected M/cc for the edge.
  task automatic issue(input int id, input logic r, input logic bub, input logic mx,
                       input logic wx, input logic [3:0] stat, input logic [3:0] icode,
                       input logic [3:0] ifun, input logic [63:0] valc,
                       input logic [63:0] vala, input logic [63:0] valb,
                       input logic [3:0] dste, input logic [3:0] dstm,
                       input logic [63:0] x_vale, input logic x_cnd,
                       input logic [3:0] x_dste, input logic [2:0] x_cc);
    exp_t e;
    rst = r; M_bubble = bub; m_exc = mx; W_exc = wx;
    E_stat = stat; E_icode = icode; E_ifun = ifun;
    E_valC = valc; E_valA = vala; E_valB = valb; E_dstE = dste; E_dstM = dstm;
    #1;
    if (!r) begin
      check($sformatf("v%0d e_valE", id), e_valE, x_vale);
      check($sformatf("v%0d e_Cnd", id), 64'(e_Cnd), 64'(x_cnd));
      check($sformatf("v%0d e_dstE", id), 64'(e_dstE), 64'(x_dste));
    end
    if (r || bub)
      e = '{stat: 4'h1, icode: 4'h1, cnd: 1'b0, val_e: '0, val_a: '0,
            dst_e: 4'hF, dst_m: 4'hF, cc: x_cc, id: id};
    else
      e = '{stat: stat, icode: icode, cnd: x_cnd, val_e: x_vale, val_a: vala,
            dst_e: x_dste, dst_m: dstm, cc: x_cc, id: id};
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: M is loaded on every edge, so every edge presents one result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check($sformatf("v%0d cc", e.id), 64'(cc), 64'(e.cc));
        check($sformatf("v%0d M_stat", e.id), 64'(M_stat), 64'(e.stat));
        check($sformatf("v%0d M_icode", e.id), 64'(M_icode), 64'(e.icode));
        check($sformatf("v%0d M_Cnd", e.id), 64'(M_Cnd), 64'(e.cnd));
        check($sformatf("v%0d M_valE", e.id), M_valE, e.val_e);
        check($sformatf("v%0d M_valA", e.id), M_valA, e.val_a);
        check($sformatf("v%0d M_dstE", e.id), 64'(M_dstE), 64'(e.dst_e));
        check($sformatf("v%0d M_dstM", e.id), 64'(M_dstM), 64'(e.dst_m));
      end
    end
  end

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NEG2 = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

  initial begin
    int waited;
    //    id rst bub mx wx stat icode ifun valC    valA     valB     dstE  dstM  x_valE   Cnd x_dstE x_cc
    issue( 1, 1, 0, 0, 0, 4'h1, 4'h1, 4'h0, 64'h0,  64'h0,   64'h0,   4'hF, 4'hF, 64'h0,   1, 4'hF, 3'b100);
    issue( 2, 0, 0, 0, 0, 4'h1, 4'h6, 4'h1, 64'h0,  64'h5,   64'h3,   4'h2, 4'hF, NEG2,    1, 4'h2, 3'b010);
    issue( 3, 0, 0, 0, 0, 4'h1, 4'h6, 4'h0, 64'h0,  MAXP,    MAXP,    4'h4, 4'hF, NEG2,    1, 4'h4, 3'b011);
    issue( 4, 0, 0, 1, 0, 4'h1, 4'h6, 4'h0, 64'h0,  64'h1,   64'h1,   4'h5, 4'hF, 64'h2,   1, 4'h5, 3'b011);
    issue( 5, 0, 0, 0, 1, 4'h1, 4'h6, 4'h0, 64'h0,  64'h0,   64'h0,   4'h5, 4'hF, 64'h0,   1, 4'h5, 3'b011);
    issue( 6, 0, 0, 0, 0, 4'h1, 4'h6, 4'h1, 64'h0,  64'h1,   MINN,    4'h6, 4'hF, MAXP,    0, 4'h6, 3'b001);
    issue( 7, 0, 0, 0, 0, 4'h1, 4'h6, 4'h3, 64'h0,  64'h42,  64'h42,  4'h7, 4'hF, 64'h0,   0, 4'h7, 3'b100);
    issue( 8, 0, 0, 0, 0, 4'h1, 4'h2, 4'h1, 64'h0,  64'h42,  64'h999, 4'h3, 4'hF, 64'h42,  1, 4'h3, 3'b100);
    issue( 9, 0, 0, 0, 0, 4'h1, 4'h6, 4'h2, 64'h0,  64'hF0,  64'h3C,  4'h1, 4'hF, 64'h30,  0, 4'h1, 3'b000);
    issue(10, 0, 0, 0, 0, 4'h1, 4'h2, 4'h1, 64'h0,  64'h42,  64'h999, 4'h3, 4'hF, 64'h42,  0, 4'hF, 3'b000);
    issue(11, 0, 0, 0, 0, 4'h1, 4'hA, 4'h0, 64'h0,  64'h77,  64'h100, 4'h4, 4'hF, 64'hF8,  1, 4'h4, 3'b000);
    issue(12, 0, 0, 0, 0, 4'h1, 4'hB, 4'h0, 64'h0,  64'h100, 64'h100, 4'h4, 4'h2, 64'h108, 1, 4'h4, 3'b000);
    issue(13, 0, 0, 0, 0, 4'h1, 4'h4, 4'h0, 64'h10, 64'h55,  64'h20,  4'hF, 4'hF, 64'h30,  1, 4'hF, 3'b000);
    issue(14, 0, 0, 0, 0, 4'h1, 4'h8, 4'h0, 64'h0,  64'h0,   64'h200, 4'h4, 4'hF, 64'h1F8, 1, 4'h4, 3'b000);
    issue(15, 0, 0, 0, 0, 4'h1, 4'h9, 4'h0, 64'h0,  64'h0,   64'h1F8, 4'h4, 4'hF, 64'h200, 1, 4'h4, 3'b000);
    issue(16, 0, 0, 0, 0, 4'h1, 4'h3, 4'h0, 64'h1234, 64'h0, 64'h55,  4'h8, 4'hF, 64'h1234,1, 4'h8, 3'b000);
    issue(17, 0, 1, 0, 0, 4'h1, 4'h6, 4'h1, 64'h0,  64'h1,   64'h1,   4'h2, 4'hF, 64'h0,   0, 4'h2, 3'b100);
    issue(18, 0, 0, 0, 0, 4'h1, 4'h7, 4'h3, 64'h400,64'h0,   64'h0,   4'hF, 4'hF, 64'h0,   1, 4'hF, 3'b100);
    issue(19, 0, 0, 0, 0, 4'h1, 4'h7, 4'h5, 64'h400,64'h0,   64'h0,   4'hF, 4'hF, 64'h0,   1, 4'hF, 3'b100);
    issue(20, 0, 0, 0, 0, 4'h1, 4'h7, 4'h6, 64'h400,64'h0,   64'h0,   4'hF, 4'hF, 64'h0,   0, 4'hF, 3'b100);
    issue(21, 0, 0, 0, 0, 4'h1, 4'h7, 4'h7, 64'h400,64'h0,   64'h0,   4'hF, 4'hF, 64'h0,   0, 4'hF, 3'b100);
    issue(22, 0, 0, 0, 0, 4'h1, 4'h6, 4'h4, 64'h0,  64'h5,   64'h3,   4'h2, 4'hF, 64'h0,   0, 4'h2, 3'b100);
    issue(23, 0, 0, 0, 0, 4'h2, 4'h0, 4'h0, 64'h0,  64'h0,   64'h0,   4'hF, 4'hF, 64'h0,   1, 4'hF, 3'b100);
    issue(24, 0, 0, 0, 0, 4'h1, 4'h6, 4'h1, 64'h0,  64'h5,   64'h3,   4'h2, 4'hF, NEG2,    1, 4'h2, 3'b010);
    issue(25, 1, 0, 0, 0, 4'h1, 4'h6, 4'h2, 64'h0,  64'hF0,  64'h3C,  4'h1, 4'hF, 64'h30,  0, 4'h1, 3'b100);
    issue(26, 0, 0, 0, 0, 4'h1, 4'h1, 4'h0, 64'h0,  64'h0,   64'h0,   4'hF, 4'hF, 64'h0,   1, 4'hF, 3'b100);

    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
